// File: rtl/bch_codeword_assembler.sv
// Merges message beats and encoder parity beats into one registered codeword stream.
// Message beats go to the encoder and to the output in the same beat; parity beats follow.
module bch_codeword_assembler #(
    parameter int Multi     = 2,
    parameter int MSG_BEATS = 256,
    parameter int PAR_BEATS = 21,
    parameter int CNT_W     = 9
) (
    input  logic                 i_clk,
    input  logic                 i_nRESET,
    input  logic                 i_start,
    input  logic [8*Multi-1:0]   i_data,
    input  logic                 i_data_valid,
    output logic                 o_data_ready,
    output logic                 o_enc_enable,
    output logic [8*Multi-1:0]   o_enc_data,
    output logic                 o_enc_data_valid,
    input  logic                 i_enc_data_ready,
    input  logic                 i_enc_data_last,
    input  logic [8*Multi-1:0]   i_par_data,
    input  logic                 i_par_valid,
    input  logic                 i_par_last,
    output logic                 o_par_ready,
    output logic [8*Multi-1:0]   o_cw_data,
    output logic                 o_cw_valid,
    output logic                 o_cw_parity,
    output logic                 o_cw_last,
    input  logic                 i_cw_ready,
    output logic                 o_busy,
    output logic                 o_error
);

    localparam int DW = 8 * Multi;

    // state  | meaning
    // S_IDLE | waiting for i_start; output register still drains
    // S_MSG  | forwarding message beats to encoder and output together
    // S_PAR  | forwarding encoder parity beats to output
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MSG  = 2'd1,
        S_PAR  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_msg_cnt;
    logic [CNT_W-1:0]   r_par_cnt;
    logic [DW-1:0]      r_cw_data;
    logic               r_cw_valid;
    logic               r_cw_parity;
    logic               r_cw_last;
    logic               r_error;

    logic               w_slot_free;
    logic               w_msg_move;
    logic               w_par_move;
    logic               w_msg_term;
    logic               w_par_term;
    logic               w_par_end;
    logic               w_start_ok;

    assign w_slot_free = !r_cw_valid || i_cw_ready;
    assign w_msg_term  = (r_msg_cnt == CNT_W'(MSG_BEATS - 1));
    assign w_par_term  = (r_par_cnt == CNT_W'(PAR_BEATS - 1));
    assign w_par_end   = i_par_last || w_par_term;
    assign w_start_ok  = (r_state == S_IDLE) && i_start;
    // Encoder and output register advance on the same condition, so neither can see a beat the other misses.
    assign w_msg_move  = (r_state == S_MSG) && i_data_valid && i_enc_data_ready && w_slot_free;
    assign w_par_move  = (r_state == S_PAR) && i_par_valid && w_slot_free;

    always_ff @(posedge i_clk or negedge i_nRESET) begin
        if (!i_nRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_state_nxt = S_MSG;
            S_MSG:  if (w_msg_move && w_msg_term) w_state_nxt = S_PAR;
            S_PAR:  if (w_par_move && w_par_end) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_data_ready     = 1'b0;
        o_enc_data_valid = 1'b0;
        o_par_ready      = 1'b0;
        o_enc_enable     = 1'b0;
        o_busy           = (r_state != S_IDLE);
        case (r_state)
            S_MSG: begin
                o_data_ready     = i_enc_data_ready && w_slot_free;
                o_enc_data_valid = i_data_valid && w_slot_free;
                o_enc_enable     = 1'b1;
            end
            S_PAR: begin
                o_par_ready  = w_slot_free;
                o_enc_enable = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nRESET) begin
        if (!i_nRESET) begin
            r_msg_cnt   <= '0;
            r_par_cnt   <= '0;
            r_cw_data   <= '0;
            r_cw_valid  <= 1'b0;
            r_cw_parity <= 1'b0;
            r_cw_last   <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_msg_cnt <= '0;
                r_par_cnt <= '0;
                r_error   <= 1'b0;
            end
            if (w_msg_move) begin
                r_msg_cnt <= r_msg_cnt + 1'b1;
                if (i_enc_data_last != w_msg_term) r_error <= 1'b1;
            end
            if (w_par_move) begin
                r_par_cnt <= r_par_cnt + 1'b1;
                if (i_par_last != w_par_term) r_error <= 1'b1;
            end

            if (w_msg_move) begin
                r_cw_data   <= i_data;
                r_cw_valid  <= 1'b1;
                r_cw_parity <= 1'b0;
                r_cw_last   <= 1'b0;
            end else if (w_par_move) begin
                r_cw_data   <= i_par_data;
                r_cw_valid  <= 1'b1;
                r_cw_parity <= 1'b1;
                r_cw_last   <= w_par_end;
            end else if (w_slot_free) begin
                r_cw_valid  <= 1'b0;
            end
        end
    end

    assign o_enc_data  = i_data;
    assign o_cw_data   = r_cw_data;
    assign o_cw_valid  = r_cw_valid;
    assign o_cw_parity = r_cw_parity;
    assign o_cw_last   = r_cw_last;
    assign o_error     = r_error;

endmodule
